// File: rtl/status_reg.sv
// 6502 processor status register (P) with per-flag ALU capture, flag ops, PLP load and IRQ mask.
// Optional decimal flag storage enabled by defining HMC6502_BCD_EN.
module status_reg #(
    parameter logic [7:0] RESET_P = 8'h34
) (
    input  logic       clk,
    input  logic       resetb,
    input  logic       alu_zero,
    input  logic       alu_negative,
    input  logic       alu_overflow,
    input  logic       alu_cout,
    input  logic [3:0] upd_mask,
    input  logic [2:0] flag_op,
    input  logic       p_load,
    input  logic [7:0] p_in,
    input  logic       push_brk,
    input  logic       sync,
    output logic [7:0] p_out,
    output logic       c_flag,
    output logic       bcd,
    output logic       irq_mask
);

    localparam logic [2:0] OP_CLC = 3'd1;
    localparam logic [2:0] OP_SEC = 3'd2;
    localparam logic [2:0] OP_CLI = 3'd3;
    localparam logic [2:0] OP_SEI = 3'd4;
    localparam logic [2:0] OP_CLV = 3'd5;
`ifdef HMC6502_BCD_EN
    localparam logic [2:0] OP_CLD = 3'd6;
    localparam logic [2:0] OP_SED = 3'd7;
`endif

    logic r_n, r_v, r_i, r_z, r_c;
    logic r_irq_mask;
    logic w_n_d, w_v_d, w_i_d, w_z_d, w_c_d;
    logic w_d;
`ifdef HMC6502_BCD_EN
    logic r_d;
    logic w_d_d;
`endif

    // Bits 5/4 of the pulled byte are never stored (and bit 3 too without decimal support).
    logic w_unused;
`ifdef HMC6502_BCD_EN
    assign w_unused = ^p_in[5:4];
`else
    assign w_unused = ^p_in[5:3];
`endif

    // Mask captures go first so a flag op on the same flag overrides them.
    always_comb begin
        w_n_d = r_n;
        w_v_d = r_v;
        w_i_d = r_i;
        w_z_d = r_z;
        w_c_d = r_c;
`ifdef HMC6502_BCD_EN
        w_d_d = r_d;
`endif
        if (p_load) begin
            w_n_d = p_in[7];
            w_v_d = p_in[6];
            w_i_d = p_in[2];
            w_z_d = p_in[1];
            w_c_d = p_in[0];
`ifdef HMC6502_BCD_EN
            w_d_d = p_in[3];
`endif
        end else begin
            if (upd_mask[3]) w_n_d = alu_negative;
            if (upd_mask[2]) w_v_d = alu_overflow;
            if (upd_mask[1]) w_z_d = alu_zero;
            if (upd_mask[0]) w_c_d = alu_cout;
            case (flag_op)
                OP_CLC:  w_c_d = 1'b0;
                OP_SEC:  w_c_d = 1'b1;
                OP_CLI:  w_i_d = 1'b0;
                OP_SEI:  w_i_d = 1'b1;
                OP_CLV:  w_v_d = 1'b0;
`ifdef HMC6502_BCD_EN
                OP_CLD:  w_d_d = 1'b0;
                OP_SED:  w_d_d = 1'b1;
`endif
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            r_n        <= RESET_P[7];
            r_v        <= RESET_P[6];
            r_i        <= RESET_P[2];
            r_z        <= RESET_P[1];
            r_c        <= RESET_P[0];
            r_irq_mask <= 1'b1;
        end else begin
            r_n <= w_n_d;
            r_v <= w_v_d;
            r_i <= w_i_d;
            r_z <= w_z_d;
            r_c <= w_c_d;
            // Samples the pre-edge I, so I writes reach the mask one boundary later.
            if (sync) r_irq_mask <= r_i;
        end
    end

`ifdef HMC6502_BCD_EN
    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            r_d <= RESET_P[3];
        end else begin
            r_d <= w_d_d;
        end
    end
    assign w_d = r_d;
`else
    assign w_d = 1'b0;
`endif

    assign p_out    = {r_n, r_v, 1'b1, push_brk, w_d, r_i, r_z, r_c};
    assign c_flag   = r_c;
    assign bcd      = w_d;
    assign irq_mask = r_irq_mask;

endmodule

// File: tb/tb_status_reg.sv
// Self-checking bench for status_reg: directed scenarios plus randomized stimulus
// against a byte-level model of P.
module tb_status_reg;

    logic       clk;
    logic       resetb;
    logic       alu_zero, alu_negative, alu_overflow, alu_cout;
    logic [3:0] upd_mask;
    logic [2:0] flag_op;
    logic       p_load;
    logic [7:0] p_in;
    logic       push_brk;
    logic       sync;
    logic [7:0] p_out;
    logic       c_flag, bcd, irq_mask;

    int n_checks = 0;
    int n_errors = 0;

`ifdef HMC6502_BCD_EN
    localparam logic [7:0] STORED = 8'hCF;
`else
    localparam logic [7:0] STORED = 8'hC7;
`endif

    // Model: P kept as a byte holding only the stored bits.
    logic [7:0] m_p;
    logic       m_irq;
    int         upd_pos [4] = '{0, 1, 6, 7};
    int         op_pos  [8] = '{0, 0, 0, 2, 2, 6, 3, 3};
    logic       op_val  [8] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};

    status_reg dut (
        .clk          (clk),
        .resetb       (resetb),
        .alu_zero     (alu_zero),
        .alu_negative (alu_negative),
        .alu_overflow (alu_overflow),
        .alu_cout     (alu_cout),
        .upd_mask     (upd_mask),
        .flag_op      (flag_op),
        .p_load       (p_load),
        .p_in         (p_in),
        .push_brk     (push_brk),
        .sync         (sync),
        .p_out        (p_out),
        .c_flag       (c_flag),
        .bcd          (bcd),
        .irq_mask     (irq_mask)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic set_in(input logic [3:0] um, input logic [2:0] fo, input logic pl,
                          input logic [7:0] pi, input logic pb, input logic sy,
                          input logic [3:0] nvzc);
        upd_mask = um;
        flag_op  = fo;
        p_load   = pl;
        p_in     = pi;
        push_brk = pb;
        sync     = sy;
        {alu_negative, alu_overflow, alu_zero, alu_cout} = nvzc;
    endtask

    task automatic check_model();
        check_eq("p_out", p_out, m_p | 8'h20 | (push_brk ? 8'h10 : 8'h00));
        check_eq("c_flag", c_flag, m_p[0]);
        check_eq("bcd", bcd, m_p[3]);
        check_eq("irq_mask", irq_mask, m_irq);
    endtask

    task automatic model_edge();
        logic       old_i;
        logic [3:0] alu_vec;
        old_i   = m_p[2];
        alu_vec = {alu_negative, alu_overflow, alu_zero, alu_cout};
        if (p_load) begin
            m_p = p_in & STORED;
        end else begin
            for (int k = 0; k < 4; k++)
                if (upd_mask[k]) m_p[upd_pos[k]] = alu_vec[k];
            if (flag_op != 3'd0) m_p[op_pos[flag_op]] = op_val[flag_op];
            m_p = m_p & STORED;
        end
        if (sync) m_irq = old_i;
    endtask

    // Called at a falling edge with inputs already applied; returns at the next falling edge.
    task automatic step();
        #1;
        check_model();
        model_edge();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        #2;
        resetb   = 1'b0;
        push_brk = 1'b0;
        #1;
        check_eq("rst_p_out_b0", p_out, 8'h24);
        check_eq("rst_irq", irq_mask, 1'b1);
        check_eq("rst_c", c_flag, 1'b0);
        check_eq("rst_bcd", bcd, 1'b0);
        push_brk = 1'b1;
        #1;
        check_eq("rst_p_out_b1", p_out, 8'h34);
        m_p   = 8'h34 & STORED;
        m_irq = 1'b1;
        @(posedge clk);
        #1;
        check_eq("rst_hold", p_out, 8'h34);
        @(negedge clk);
        resetb = 1'b1;
    endtask

    initial begin
        resetb = 1'b1;
        set_in(4'h0, 3'd0, 1'b0, 8'h00, 1'b0, 1'b0, 4'h0);
        m_p   = 8'h04;
        m_irq = 1'b1;
        do_reset();

        // ALU capture under mask
        set_in(4'b1011, 3'd0, 1'b0, 8'h00, 1'b0, 1'b0, 4'b1101);
        step();
        check_eq("alu_capture", p_out, 8'hA5);

        // flag op beats mask on C, Z still captured
        set_in(4'b0011, 3'd1, 1'b0, 8'h00, 1'b0, 1'b0, 4'b0011);
        step();
        check_eq("conflict", p_out, 8'hA6);

        // PLP overrides flag op
        set_in(4'b0000, 3'd2, 1'b1, 8'hFF, 1'b0, 1'b0, 4'b0000);
        step();
`ifdef HMC6502_BCD_EN
        check_eq("plp", p_out, 8'hEF);
`else
        check_eq("plp", p_out, 8'hE7);
`endif
        check_eq("plp_c", c_flag, 1'b1);

        // IRQ mask latency
        set_in(4'h0, 3'd4, 1'b0, 8'h00, 1'b0, 1'b0, 4'h0); step();
        set_in(4'h0, 3'd0, 1'b0, 8'h00, 1'b0, 1'b1, 4'h0); step();
        set_in(4'h0, 3'd3, 1'b0, 8'h00, 1'b0, 1'b0, 4'h0); step();
        check_eq("cli_nosync", irq_mask, 1'b1);
        set_in(4'h0, 3'd0, 1'b0, 8'h00, 1'b0, 1'b1, 4'h0); step();
        check_eq("cli_after_sync", irq_mask, 1'b0);
        set_in(4'h0, 3'd4, 1'b0, 8'h00, 1'b0, 1'b0, 4'h0); step();
        set_in(4'h0, 3'd0, 1'b0, 8'h00, 1'b0, 1'b1, 4'h0); step();
        set_in(4'h0, 3'd3, 1'b0, 8'h00, 1'b0, 1'b1, 4'h0); step();
        check_eq("cli_with_sync", irq_mask, 1'b1);
        set_in(4'h0, 3'd0, 1'b0, 8'h00, 1'b0, 1'b1, 4'h0); step();
        check_eq("cli_next_sync", irq_mask, 1'b0);

        // Decimal flag
        set_in(4'h0, 3'd7, 1'b0, 8'h00, 1'b0, 1'b0, 4'h0); step();
`ifdef HMC6502_BCD_EN
        check_eq("sed", bcd, 1'b1);
`else
        check_eq("sed", bcd, 1'b0);
`endif
        set_in(4'h0, 3'd6, 1'b0, 8'h00, 1'b0, 1'b0, 4'h0); step();
        check_eq("cld", bcd, 1'b0);

        // Randomized traffic with occasional mid-cycle reset
        for (int n = 0; n < 600; n++) begin
            if ($urandom_range(0, 79) == 0) do_reset();
            set_in(4'($urandom),
                   ($urandom_range(0, 1) == 1) ? 3'($urandom) : 3'd0,
                   ($urandom_range(0, 7) == 0),
                   8'($urandom),
                   1'($urandom),
                   ($urandom_range(0, 2) == 0),
                   4'($urandom));
            step();
        end
        #1;
        check_model();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
